// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side drain engine.
// Holds buffer depth and the occupancy count type.
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] cnt_t;

endpackage

// File: rtl/rd_stream_buf.sv
// Two-entry in-order register queue; head is always slot 0.
// Ports: clk, rst_n, clr, push/push_data, pop -> head, count.
module rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output cnt_t             count
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  cnt_t             cnt_q, cnt_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            slot0_d = push_data;
            cnt_d   = 2'd1;
          end
        end
        2'd1: begin
          // push+pop on a single entry replaces the head in place
          if (push && pop) begin
            slot0_d = push_data;
          end else if (push) begin
            slot1_d = push_data;
            cnt_d   = 2'd2;
          end else if (pop) begin
            cnt_d = 2'd0;
          end
        end
        default: begin
          if (pop) begin
            slot0_d = slot1_q;
            if (push) begin
              slot1_d = push_data;
            end else begin
              cnt_d = 2'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign head  = slot0_q;
  assign count = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous FIFO into a valid/ready stream.
// Ports: fifo_empty/fifo_rd_en/fifo_dout, m_valid/m_ready/m_data, clr, words_out.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] words_out
);

  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] words_q, words_d;
  cnt_t             count;
  logic             pop;
  logic [2:0]       occ;

  assign pop     = m_valid && m_ready;
  assign m_valid = (count != 2'd0);

  // slots committed after this edge: buffered + arriving - leaving
  assign occ = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};

  // rst_n gate keeps the read port quiet while held in reset
  assign fifo_rd_en = rst_n && !fifo_empty && !clr
                   && (occ < 3'(BUF_DEPTH));

  always_comb begin
    inflight_d = fifo_rd_en;
    words_d    = words_q;
    if (clr) begin
      words_d = '0;
    end else if (pop) begin
      words_d = words_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      words_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      words_q    <= words_d;
    end
  end

  rd_stream_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (inflight_q && !clr),
    .push_data(fifo_dout),
    .pop      (pop && !clr),
    .head     (m_data),
    .count    (count)
  );

  assign words_out = words_q;

endmodule
